// File: rtl/emu_axi_mem_responder.sv
// AXI4 responder that serves full-width bursts from an on-chip synchronous RAM array.
// Stands in for board DRAM behind the RAM timing model. Independent read and write engines,
// one outstanding transaction each.
// Optional decode-error reporting: define EMU_MEM_RESP_DECERR_EN to flag beats outside the
// array window with DECERR. Without it, addresses alias modulo the array depth.
module emu_axi_mem_responder #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 64,
  parameter int unsigned           ID_WIDTH   = 4,
  parameter int unsigned           MEM_AW     = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                    clk,
  input  logic                    resetn,
  // Write address
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  // Write data
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  // Write response
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  output logic [1:0]              s_axi_bresp,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  // Read address
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  // Read data
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic                    s_axi_rlast
);

  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam int unsigned OffW  = $clog2(StrbW);
  localparam int unsigned Depth = 2 ** MEM_AW;
  localparam logic [ADDR_WIDTH-1:0] OffMask  = ADDR_WIDTH'(StrbW - 1);
  localparam logic [ADDR_WIDTH-1:0] WordStep = ADDR_WIDTH'(StrbW);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

`ifdef EMU_MEM_RESP_DECERR_EN
  localparam bit DecErrEn = 1'b1;
`else
  localparam bit DecErrEn = 1'b0;
`endif

  // Beat size is fixed at full width, so the size fields carry no information.
  logic unused_size;
  assign unused_size = ^{s_axi_awsize, s_axi_arsize};

  // Word index inside the array; byte-offset bits dropped, upper bits alias.
  function automatic logic [MEM_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return MEM_AW'(off >> OffW);
  endfunction

  function automatic logic out_of_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    if (!DecErrEn) return 1'b0;
    if (addr < BASE_ADDR) return 1'b1;
    return (off >> (MEM_AW + OffW)) != '0;
  endfunction

  // Address of the following beat. WRAP only wraps for power-of-two bursts of 2..16 beats.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [7:0]            len,
                                                      input logic [1:0]            burst);
    logic [ADDR_WIDTH-1:0] wa;
    logic [ADDR_WIDTH-1:0] mask;
    logic [ADDR_WIDTH-1:0] nwa;
    logic                  wrap_ok;
    wa      = addr >> OffW;
    mask    = ADDR_WIDTH'(len);
    nwa     = (wa & ~mask) | ((wa + ADDR_WIDTH'(1)) & mask);
    wrap_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    if (burst == 2'b00) return addr;
    if ((burst == 2'b10) && wrap_ok) return (nwa << OffW) | (addr & OffMask);
    return addr + WordStep;
  endfunction

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

  logic [DATA_WIDTH-1:0] mem [Depth];

  // ---------------------------------------------------------------------------
  // Write engine
  // ---------------------------------------------------------------------------
  w_state_e              w_state_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q;
  logic [7:0]            w_cnt_q;
  logic [1:0]            w_burst_q;
  logic [ID_WIDTH-1:0]   w_id_q;
  logic                  w_slverr_q;
  logic                  w_decerr_q;
  logic                  awready_q;
  logic                  wready_q;
  logic                  bvalid_q;
  logic [1:0]            bresp_q;
  logic [ID_WIDTH-1:0]   bid_q;

  logic                  w_hs;
  logic                  w_last_beat;
  logic                  w_oor;
  logic                  w_wlast_err;
  logic [MEM_AW-1:0]     w_idx;

  assign w_hs        = s_axi_wvalid && wready_q;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_oor       = out_of_range(w_addr_q);
  assign w_wlast_err = (s_axi_wlast != w_last_beat);
  assign w_idx       = word_idx(w_addr_q);

  // Write FSM: AW latch, beat counting, response generation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      w_state_q  <= WIdle;
      w_addr_q   <= '0;
      w_len_q    <= '0;
      w_cnt_q    <= '0;
      w_burst_q  <= '0;
      w_id_q     <= '0;
      w_slverr_q <= 1'b0;
      w_decerr_q <= 1'b0;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RespOkay;
      bid_q      <= '0;
    end else begin
      unique case (w_state_q)
        WIdle: begin
          awready_q <= 1'b1;
          if (s_axi_awvalid && awready_q) begin
            w_addr_q   <= s_axi_awaddr;
            w_len_q    <= s_axi_awlen;
            w_burst_q  <= s_axi_awburst;
            w_id_q     <= s_axi_awid;
            w_cnt_q    <= '0;
            w_slverr_q <= 1'b0;
            w_decerr_q <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            w_state_q  <= WData;
          end
        end
        WData: begin
          if (w_hs) begin
            w_addr_q   <= next_addr(w_addr_q, w_len_q, w_burst_q);
            w_cnt_q    <= w_cnt_q + 8'd1;
            w_slverr_q <= w_slverr_q | w_wlast_err;
            w_decerr_q <= w_decerr_q | w_oor;
            // The burst ends on the beat count alone; wlast only grades it.
            if (w_last_beat) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bid_q     <= w_id_q;
              w_state_q <= WResp;
              if (w_decerr_q || w_oor) begin
                bresp_q <= RespDecErr;
              end else if (w_slverr_q || w_wlast_err) begin
                bresp_q <= RespSlvErr;
              end else begin
                bresp_q <= RespOkay;
              end
            end
          end
        end
        WResp: begin
          if (s_axi_bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            w_state_q <= WIdle;
          end
        end
        default: w_state_q <= WIdle;
      endcase
    end
  end

  // Array write port with byte enables; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (resetn && w_hs && !w_oor) begin
      for (int b = 0; b < StrbW; b++) begin
        if (s_axi_wstrb[b]) begin
          mem[w_idx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready_q;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_bid     = bid_q;

  // ---------------------------------------------------------------------------
  // Read engine
  // ---------------------------------------------------------------------------
  r_state_e              r_state_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;
  logic [7:0]            r_len_q;
  logic [7:0]            r_cnt_q;
  logic [1:0]            r_burst_q;
  logic                  arready_q;
  logic                  rvalid_q;
  logic                  rlast_q;
  logic [1:0]            rresp_q;
  logic [ID_WIDTH-1:0]   rid_q;
  logic                  r_zero_q;
  logic [DATA_WIDTH-1:0] ram_q;

  logic                  r_hs;
  logic [ADDR_WIDTH-1:0] r_next_addr;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_oor;

  assign r_hs        = rvalid_q && s_axi_rready;
  assign r_next_addr = next_addr(r_addr_q, r_len_q, r_burst_q);
  assign rd_oor      = out_of_range(rd_addr);

  // Read issue: first word in RFetch, later words on each non-last R handshake.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = r_addr_q;
    if (r_state_q == RFetch) begin
      rd_en = 1'b1;
    end else if ((r_state_q == RData) && r_hs && !rlast_q) begin
      rd_en   = 1'b1;
      rd_addr = r_next_addr;
    end
  end

  // Array read port; holds its value between issues so R stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      ram_q <= mem[word_idx(rd_addr)];
    end
  end

  // Read FSM: AR latch, beat sequencing, per-beat response.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state_q <= RIdle;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_cnt_q   <= '0;
      r_burst_q <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RespOkay;
      rid_q     <= '0;
      r_zero_q  <= 1'b1;
    end else begin
      unique case (r_state_q)
        RIdle: begin
          arready_q <= 1'b1;
          if (s_axi_arvalid && arready_q) begin
            r_addr_q  <= s_axi_araddr;
            r_len_q   <= s_axi_arlen;
            r_burst_q <= s_axi_arburst;
            rid_q     <= s_axi_arid;
            r_cnt_q   <= '0;
            arready_q <= 1'b0;
            r_state_q <= RFetch;
          end
        end
        RFetch: begin
          rvalid_q  <= 1'b1;
          rlast_q   <= (r_len_q == 8'd0);
          rresp_q   <= rd_oor ? RespDecErr : RespOkay;
          r_zero_q  <= rd_oor;
          r_state_q <= RData;
        end
        RData: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              arready_q <= 1'b1;
              r_state_q <= RIdle;
            end else begin
              r_addr_q <= r_next_addr;
              r_cnt_q  <= r_cnt_q + 8'd1;
              rlast_q  <= ((r_cnt_q + 8'd1) == r_len_q);
              rresp_q  <= rd_oor ? RespDecErr : RespOkay;
              r_zero_q <= rd_oor;
            end
          end
        end
        default: r_state_q <= RIdle;
      endcase
    end
  end

  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rdata   = r_zero_q ? '0 : ram_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rlast   = rlast_q;

endmodule

// File: tb/tb_emu_axi_mem_responder.sv
// Directed bench for emu_axi_mem_responder: read beats are checked against a scoreboard of
// expected beats queued before each read is issued.
module tb_emu_axi_mem_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        s_axi_awvalid, s_axi_awready;
  logic [31:0] s_axi_awaddr;
  logic [3:0]  s_axi_awid;
  logic [7:0]  s_axi_awlen;
  logic [2:0]  s_axi_awsize;
  logic [1:0]  s_axi_awburst;
  logic        s_axi_wvalid, s_axi_wready;
  logic [63:0] s_axi_wdata;
  logic [7:0]  s_axi_wstrb;
  logic        s_axi_wlast;
  logic        s_axi_bvalid, s_axi_bready;
  logic [1:0]  s_axi_bresp;
  logic [3:0]  s_axi_bid;
  logic        s_axi_arvalid, s_axi_arready;
  logic [31:0] s_axi_araddr;
  logic [3:0]  s_axi_arid;
  logic [7:0]  s_axi_arlen;
  logic [2:0]  s_axi_arsize;
  logic [1:0]  s_axi_arburst;
  logic        s_axi_rvalid, s_axi_rready;
  logic [63:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic [3:0]  s_axi_rid;
  logic        s_axi_rlast;

  always #5 clk = ~clk;

  emu_axi_mem_responder dut (
    .clk           (clk),
    .resetn        (resetn),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awid    (s_axi_awid),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bid     (s_axi_bid),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arid    (s_axi_arid),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rid     (s_axi_rid),
    .s_axi_rlast   (s_axi_rlast)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rexp_t;

  rexp_t       sb [$];
  logic [63:0] wbeats [16];
  int          checks = 0;
  int          fails  = 0;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] r, input logic l,
                      input logic [3:0] id);
    rexp_t e;
    e.data = d;
    e.resp = r;
    e.last = l;
    e.id   = id;
    sb.push_back(e);
  endtask

  task automatic idle_bus();
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awid = '0; s_axi_awlen = '0;
    s_axi_awsize  = 3'd3; s_axi_awburst = 2'b01;
    s_axi_wvalid  = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_bready  = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arid = '0; s_axi_arlen = '0;
    s_axi_arsize  = 3'd3; s_axi_arburst = 2'b01;
    s_axi_rready  = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge after the B handshake.
  task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input logic [7:0] strb, input int last_beat,
                          output logic [1:0] resp, output logic [3:0] bid);
    int n;
    s_axi_awaddr = addr; s_axi_awid = id; s_axi_awlen = 8'(len); s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin @(negedge clk); n++; end
    chk("aw_wait", 72'(n < 50), 72'd1);
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wdata = wbeats[i]; s_axi_wstrb = strb; s_axi_wlast = (i == last_beat);
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin @(negedge clk); n++; end
    chk("b_wait", 72'(n < 50), 72'd1);
    resp = s_axi_bresp;
    bid  = s_axi_bid;
    @(negedge clk);
    s_axi_bready = 1'b0;
  endtask

  // Issues AR, checks the 2-cycle latency, then drains beats against the scoreboard.
  task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input int len,
                         input logic [1:0] burst, input bit toggle);
    int          n;
    int          beats;
    int          cyc;
    logic [63:0] held;
    bit          stalled;
    rexp_t       e;
    s_axi_araddr = addr; s_axi_arid = id; s_axi_arlen = 8'(len); s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin @(negedge clk); n++; end
    chk("ar_wait", 72'(n < 50), 72'd1);
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    chk("r_lat_early", 72'(s_axi_rvalid), 72'd0);
    @(negedge clk);
    chk("r_lat", 72'(s_axi_rvalid), 72'd1);
    beats = 0; cyc = 0; stalled = 1'b0; held = '0;
    while (beats <= len && cyc < 200) begin
      s_axi_rready = toggle ? cyc[0] : 1'b1;
      if (s_axi_rvalid) begin
        if (stalled) chk("r_hold", 72'(s_axi_rdata), 72'(held));
        if (s_axi_rready) begin
          if (sb.size() == 0) begin
            chk("sb_empty", 72'd1, 72'd0);
          end else begin
            e = sb.pop_front();
            chk("r_beat", 72'({s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid}), 72'(e));
          end
          beats++;
          stalled = 1'b0;
        end else begin
          held    = s_axi_rdata;
          stalled = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    s_axi_rready = 1'b0;
    chk("r_cycles", 72'(cyc), toggle ? 72'(2 * (len + 1)) : 72'(len + 1));
    chk("r_done", 72'(s_axi_rvalid), 72'd0);
    chk("sb_drained", 72'(sb.size()), 72'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] resp;
    logic [3:0] bid;
    bit         seen;

    idle_bus();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", 72'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                        s_axi_rvalid, s_axi_rlast}), 72'd0);
    chk("rst_data", 72'(s_axi_rdata), 72'd0);
    chk("rst_resp", 72'({s_axi_bresp, s_axi_rresp, s_axi_bid, s_axi_rid}), 72'd0);
    resetn = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 72'({s_axi_awready, s_axi_arready}), 72'b11);

    // Reset in the middle of a write burst and a stalled read burst.
    s_axi_awaddr = 32'h200; s_axi_awid = 4'h1; s_axi_awlen = 8'd3; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    s_axi_wdata = 64'h11; s_axi_wstrb = 8'hFF; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0;
    s_axi_araddr = 32'h100; s_axi_arid = 4'h2; s_axi_arlen = 8'd3; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("mid_busy", 72'({s_axi_rvalid, s_axi_wready}), 72'b11);
    resetn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_ctl", 72'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                              s_axi_rvalid}), 72'd0);
    end
    resetn = 1'b1;
    @(negedge clk);
    chk("rel_ready", 72'({s_axi_awready, s_axi_arready, s_axi_wready, s_axi_bvalid,
                          s_axi_rvalid}), 72'b11000);
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= s_axi_bvalid | s_axi_rvalid;
    end
    chk("no_stale", 72'(seen), 72'd0);

    // INCR write then INCR read at full rate.
    wbeats[0] = 64'd1; wbeats[1] = 64'd2; wbeats[2] = 64'd3; wbeats[3] = 64'd4;
    do_write(32'h100, 4'h3, 3, 2'b01, 8'hFF, 3, resp, bid);
    chk("incr_bresp", 72'(resp), 72'd0);
    chk("incr_bid", 72'(bid), 72'h3);
    push(64'd1, 2'b00, 1'b0, 4'hA); push(64'd2, 2'b00, 1'b0, 4'hA);
    push(64'd3, 2'b00, 1'b0, 4'hA); push(64'd4, 2'b00, 1'b1, 4'hA);
    do_read(32'h100, 4'hA, 3, 2'b01, 1'b0);

    // WRAP len 3 from 0x118 wraps inside 0x100..0x11F.
    push(64'd4, 2'b00, 1'b0, 4'h6); push(64'd1, 2'b00, 1'b0, 4'h6);
    push(64'd2, 2'b00, 1'b0, 4'h6); push(64'd3, 2'b00, 1'b1, 4'h6);
    do_read(32'h118, 4'h6, 3, 2'b10, 1'b0);

    // WRAP with len 2 behaves as INCR.
    push(64'd2, 2'b00, 1'b0, 4'h7); push(64'd3, 2'b00, 1'b0, 4'h7);
    push(64'd4, 2'b00, 1'b1, 4'h7);
    do_read(32'h108, 4'h7, 2, 2'b10, 1'b0);

    // Byte strobes, and R held stable under rready backpressure.
    for (int i = 0; i < 4; i++) wbeats[i] = '1;
    do_write(32'h300, 4'h0, 3, 2'b01, 8'hFF, 3, resp, bid);
    chk("ones_bresp", 72'(resp), 72'd0);
    wbeats[0] = '0;
    do_write(32'h300, 4'h0, 0, 2'b01, 8'h0F, 0, resp, bid);
    push(64'hFFFFFFFF_00000000, 2'b00, 1'b0, 4'h1);
    push(64'hFFFFFFFF_FFFFFFFF, 2'b00, 1'b0, 4'h1);
    push(64'hFFFFFFFF_FFFFFFFF, 2'b00, 1'b0, 4'h1);
    push(64'hFFFFFFFF_FFFFFFFF, 2'b00, 1'b1, 4'h1);
    do_read(32'h300, 4'h1, 3, 2'b01, 1'b1);

    // FIXED burst: every beat hits the same word.
    wbeats[0] = 64'hA; wbeats[1] = 64'hB; wbeats[2] = 64'hC;
    do_write(32'h400, 4'h2, 2, 2'b00, 8'hFF, 2, resp, bid);
    push(64'hC, 2'b00, 1'b0, 4'h2); push(64'hC, 2'b00, 1'b1, 4'h2);
    do_read(32'h400, 4'h2, 1, 2'b00, 1'b0);

    // Early wlast: all beats still taken, SLVERR reported.
    wbeats[0] = 64'h50; wbeats[1] = 64'h51; wbeats[2] = 64'h52; wbeats[3] = 64'h53;
    do_write(32'h500, 4'h5, 3, 2'b01, 8'hFF, 1, resp, bid);
    chk("early_wlast_bresp", 72'(resp), 72'b10);
    chk("early_wlast_bid", 72'(bid), 72'h5);
    push(64'h50, 2'b00, 1'b0, 4'h3); push(64'h51, 2'b00, 1'b0, 4'h3);
    push(64'h52, 2'b00, 1'b0, 4'h3); push(64'h53, 2'b00, 1'b1, 4'h3);
    do_read(32'h500, 4'h3, 3, 2'b01, 1'b0);

    // Missing wlast.
    wbeats[0] = 64'h60; wbeats[1] = 64'h61;
    do_write(32'h600, 4'h9, 1, 2'b01, 8'hFF, -1, resp, bid);
    chk("no_wlast_bresp", 72'(resp), 72'b10);
    chk("no_wlast_bid", 72'(bid), 72'h9);

    // Address just past the array.
    wbeats[0] = 64'h1234;
    do_write(32'h0, 4'h0, 0, 2'b01, 8'hFF, 0, resp, bid);
    chk("w0_bresp", 72'(resp), 72'd0);
    wbeats[0] = 64'hDEAD;
    do_write(32'h80000, 4'h4, 0, 2'b01, 8'hFF, 0, resp, bid);
`ifdef EMU_MEM_RESP_DECERR_EN
    chk("oor_bresp", 72'(resp), 72'b11);
    push(64'h0, 2'b11, 1'b1, 4'h4);
    do_read(32'h80000, 4'h4, 0, 2'b01, 1'b0);
    push(64'h1234, 2'b00, 1'b1, 4'h4);
    do_read(32'h0, 4'h4, 0, 2'b01, 1'b0);
`else
    chk("alias_bresp", 72'(resp), 72'd0);
    push(64'hDEAD, 2'b00, 1'b1, 4'h4);
    do_read(32'h80000, 4'h4, 0, 2'b01, 1'b0);
    push(64'hDEAD, 2'b00, 1'b1, 4'h4);
    do_read(32'h0, 4'h4, 0, 2'b01, 1'b0);
`endif

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
